// File: rtl/heartbeat_multi.sv
// heartbeat_multi: multi-channel staggered heartbeat/blink pattern generator.
// Each channel runs its own phase counter off a shared prescaled tick.
module heartbeat_multi #(
  parameter int CHANNELS       = 4,
  parameter int PRESCALE       = 1000,
  parameter int PRESCALE_W     = 16,
  parameter int PERIOD_W       = 8,
  parameter int DEFAULT_PERIOD = 64,
  parameter int OFFSET         = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ena_i,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [1:0]          mode_i,
  output logic [CHANNELS-1:0] beat_out_o,
  output logic                beat_strobe_o,
  output logic [7:0]          beat_count_o
);
  localparam int HW = $clog2((CHANNELS-1)*OFFSET+2);
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PERIOD_W-1:0] per_q, w, w2, w3, half;
  logic [1:0] mode_q;
  logic tick, wrap_q, wrap_d;
  logic [CHANNELS-1:0] f;
  assign tick  = ena_i && pre_q == PRESCALE_W'(PRESCALE-1);
  assign pre_d = !ena_i ? pre_q : tick ? '0 : pre_q + 1'b1;
  assign w     = per_q >> 3;
  assign w2    = w << 1;
  assign w3    = w2 + w;
  assign half  = per_q >> 1;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PERIOD_W-1:0] ph_q, ph_d;
    logic [HW-1:0] ho_q, ho_d;
    // while held off the phase is frozen and the output forced low
    assign ho_d = tick && ho_q != '0 ? ho_q - 1'b1 : ho_q;
    assign ph_d = tick && ho_q == '0 ? (ph_q == per_q - 1'b1 ? '0 : ph_q + 1'b1) : ph_q;
    assign f[c] = ho_q != '0 ? 1'b0 :
                  mode_q == 2'b01 ? (ph_q < w || (ph_q >= w2 && ph_q < w3)) :
                  mode_q == 2'b10 ? ph_q < half :
                  mode_q == 2'b11;
    always_ff @(posedge clk_i) begin
      if (!rst_ni || load_i) begin
        ph_q <= '0;
        ho_q <= HW'(c*OFFSET);
      end else begin
        ph_q <= ph_d;
        ho_q <= ho_d;
      end
    end
  end
  assign wrap_d = tick && !load_i && g_ch[0].ho_q == '0 && g_ch[0].ph_q == per_q - 1'b1;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pre_q         <= '0;
      per_q         <= PERIOD_W'(DEFAULT_PERIOD);
      mode_q        <= 2'b01;
      wrap_q        <= 1'b0;
      beat_out_o    <= '0;
      beat_strobe_o <= 1'b0;
      beat_count_o  <= '0;
    end else begin
      beat_out_o    <= f;
      wrap_q        <= wrap_d;
      beat_strobe_o <= load_i ? 1'b0 : wrap_q;
      beat_count_o  <= load_i ? 8'd0 : beat_count_o + {7'd0, wrap_q};
      pre_q         <= load_i ? '0 : pre_d;
      if (load_i) begin
        per_q  <= period_i < PERIOD_W'(8) ? PERIOD_W'(8) : period_i;
        mode_q <= mode_i;
      end
    end
  end
endmodule
